// File: rtl/aes_ahb_master.sv
// aes_ahb_master
// AHB-Lite initiator that programs the AES128 peripheral: writes the key and
// plaintext word by word, starts encryption, polls DONE_STATUS, reads the
// ciphertext back and returns it on a valid/ready response port.
//
// Ports
//   HCLK, HRESETn         clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd_key, cmd_text     128-bit key / plaintext, word i = bits [32i+31:32i]
//   rsp_valid/rsp_ready   response handshake; rsp_valid held until rsp_ready
//   rsp_cipher            ciphertext, word i read from offset 0x24+4i
//   rsp_error             poll timeout flag, valid with rsp_valid
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA   AHB-Lite address and data phase outputs
//   HRDATA/HREADY         AHB-Lite read data and data-phase completion
//
// Handshakes: a transfer on cmd or rsp happens on a rising edge where both
// valid and ready are high; valid never depends combinationally on ready.
//
// Build option: define AES_MST_TIMEOUT_EN to bound DONE_STATUS polling to
// POLL_LIMIT reads returning 0; otherwise polling is unbounded and rsp_error
// is tied low.
//
// Step index -> transfer:
//   0-3  write key word i      @ 0x00+4i     4-7  write text word i-4 @ 0x10+4(i-4)
//   8    write 1 to CTRL 0x20               9    read DONE_STATUS 0x34 (repeat while bit0=0)
//   10-13 read CIPHER 0x24..0x30            14   write 0 to CTRL 0x20, then RESP
module aes_ahb_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [127:0] cmd_key,
  input  logic [127:0] cmd_text,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_cipher,
  output logic         rsp_error,
  output logic [31:0]  HADDR,
  output logic [1:0]   HTRANS,
  output logic         HWRITE,
  output logic [2:0]   HSIZE,
  output logic [31:0]  HWDATA,
  input  logic [31:0]  HRDATA,
  input  logic         HREADY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t       state, state_next;
  logic [3:0]   step, step_next;
  logic [127:0] key_q, text_q;

  logic [31:0]  offset;
  logic         is_write;
  logic [31:0]  wdata;
  logic [1:0]   cidx;        // cipher word index for steps 10-13
  logic         accept;
  logic         data_done;   // data phase completes this edge
  logic         poll_zero;   // DONE_STATUS read returned 0
  logic         timeout_hit; // this zero poll is the last one allowed

  assign accept    = (state == IDLE) && cmd_valid;
  assign data_done = (state == DATA) && HREADY;
  assign poll_zero = data_done && (step == 4'd9) && !HRDATA[0];
  // 10->0, 11->1, 12->2, 13->3 using only the low two bits
  assign cidx      = step[1:0] + 2'd2;

  // Per-step transfer decode
  always_comb begin
    offset   = 32'h0;
    is_write = 1'b0;
    wdata    = 32'h0;
    if (step <= 4'd7) begin
      offset   = {27'd0, step[2:0], 2'b00};
      is_write = 1'b1;
      wdata    = step[2] ? text_q[{step[1:0], 5'd0} +: 32] : key_q[{step[1:0], 5'd0} +: 32];
    end else if (step == 4'd8) begin
      offset   = 32'h20;
      is_write = 1'b1;
      wdata    = 32'h1;
    end else if (step == 4'd9) begin
      offset   = 32'h34;
    end else if (step <= 4'd13) begin
      offset   = 32'h24 + {28'd0, cidx, 2'b00};
    end else if (step == 4'd14) begin
      offset   = 32'h20;
      is_write = 1'b1;
      wdata    = 32'h0;
    end
  end

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      step  <= 4'd0;
    end else begin
      state <= state_next;
      step  <= step_next;
    end
  end

  // FSM next state and step sequencing
  always_comb begin
    state_next = state;
    step_next  = step;
    case (state)
      IDLE: if (cmd_valid) begin
        state_next = ADDR;
        step_next  = 4'd0;
      end
      ADDR: if (HREADY) state_next = DATA;
      DATA: if (HREADY) begin
        if (step == 4'd14) begin
          state_next = RESP;
        end else begin
          state_next = ADDR;
          if (poll_zero) step_next = timeout_hit ? 4'd14 : 4'd9;
          else           step_next = step + 4'd1;
        end
      end
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latch and ciphertext capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      key_q      <= '0;
      text_q     <= '0;
      rsp_cipher <= '0;
    end else begin
      if (accept) begin
        key_q  <= cmd_key;
        text_q <= cmd_text;
      end
      if (data_done && (step inside {[4'd10:4'd13]}))
        rsp_cipher[{cidx, 5'd0} +: 32] <= HRDATA;
      else if (poll_zero && timeout_hit)
        rsp_cipher <= '0;
    end
  end

`ifdef AES_MST_TIMEOUT_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);
  logic [PW-1:0] poll_cnt;

  assign timeout_hit = (poll_cnt == PW'(POLL_LIMIT - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      poll_cnt  <= '0;
      rsp_error <= 1'b0;
    end else if (accept) begin
      poll_cnt  <= '0;
      rsp_error <= 1'b0;
    end else if (poll_zero) begin
      poll_cnt <= poll_cnt + PW'(1);
      if (timeout_hit) rsp_error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_error   = 1'b0;
`endif

  // Bus and handshake outputs; address and data held while HREADY is low
  // because they depend only on state and step.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign HSIZE     = 3'b010;
  assign HTRANS    = (state == ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = ((state == ADDR) || (state == DATA)) ? (BASE_ADDR + offset) : 32'h0;
  assign HWRITE    = ((state == ADDR) || (state == DATA)) && is_write;
  assign HWDATA    = ((state == DATA) && is_write) ? wdata : 32'h0;

endmodule
